// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Merges CH_NUM byte producers onto the single UART transmit input. Each
// channel owns a DEPTH-entry FIFO. An arbiter grants one channel per byte.
// The granted byte stays on data_send until the UART pulses data_ready.
// Optional feature macro: UART_TX_ARB_RR_EN. When it is defined, arbitration
// is round-robin. When it is not defined, arbitration is fixed priority and
// the lowest index wins.
module uart_tx_arbiter #(
    parameter int                CH_NUM    = 2,
    parameter int                DEPTH     = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] IDLE_BYTE = '0
) (
    input  logic                     uart_clk,
    input  logic                     reset,
    input  logic [CH_NUM-1:0]        ch_enable,
    input  logic [CH_NUM-1:0]        flush,
    input  logic [CH_NUM*DATA_W-1:0] in_bits,
    input  logic [CH_NUM-1:0]        in_valid,
    output logic [CH_NUM-1:0]        in_ready,
    output logic [CH_NUM-1:0]        overflow,
    input  logic                     data_ready,
    output logic [DATA_W-1:0]        data_send,
    output logic [CH_NUM-1:0]        grant,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t              state_q;
    logic [PW-1:0]       wrPtr_q [CH_NUM];
    logic [PW-1:0]       rdPtr_q [CH_NUM];
    logic [PW-1:0]       wrPtr_d [CH_NUM];
    logic [PW-1:0]       rdPtr_d [CH_NUM];
    logic [DATA_W-1:0]   mem_q   [CH_NUM][DEPTH];
    logic [CH_NUM-1:0]   inReady_q;
    logic [CH_NUM-1:0]   overflow_q;
    logic [CH_NUM-1:0]   grant_q;
    logic [DATA_W-1:0]   dataSend_q;
    logic                busy_q;
    logic [CW-1:0]       winIdx_q;

    logic [CH_NUM-1:0]   empty;
    logic [CH_NUM-1:0]   full_d;
    logic [CH_NUM-1:0]   push;
    logic [CH_NUM-1:0]   pop;
    logic [CH_NUM-1:0]   eligible;
    logic                anyEligible;
    logic [CW-1:0]       pick;

`ifdef UART_TX_ARB_RR_EN
    logic [CW-1:0]       rrPtr_q;
    logic                found;
    int                  idx;
`endif

    // Per-channel FIFO bookkeeping.
    // A flush beats both a push and a pop on the same channel and leaves the FIFO empty.
    // The full flag uses the post-edge pointers so that in_ready can be registered.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            empty[i]    = (wrPtr_q[i] == rdPtr_q[i]);
            push[i]     = in_valid[i] & inReady_q[i] & ~flush[i];
            pop[i]      = (state_q == SEND) & data_ready & ~flush[i] & (winIdx_q == CW'(i));
            eligible[i] = ch_enable[i] & ~empty[i] & ~flush[i];
            if (flush[i]) begin
                wrPtr_d[i] = wrPtr_q[i];
                rdPtr_d[i] = wrPtr_q[i];
            end else begin
                wrPtr_d[i] = wrPtr_q[i] + PW'(push[i]);
                rdPtr_d[i] = rdPtr_q[i] + PW'(pop[i]);
            end
            full_d[i] = (wrPtr_d[i][AW] != rdPtr_d[i][AW]) &&
                        (wrPtr_d[i][AW-1:0] == rdPtr_d[i][AW-1:0]);
        end
    end

    // Pick the next owner from the eligible channels.
    // A channel being flushed this cycle is never eligible.
    always_comb begin
        anyEligible = |eligible;
        pick        = '0;
`ifdef UART_TX_ARB_RR_EN
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < CH_NUM; k++) begin
            idx = (int'(rrPtr_q) + k) % CH_NUM;
            if (!found && eligible[idx[CW-1:0]]) begin
                found = 1'b1;
                pick  = CW'(idx);
            end
        end
`else
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                pick = CW'(k);
            end
        end
`endif
    end

    // FIFO storage, pointers, registered in_ready and sticky overflow flags.
    always_ff @(posedge uart_clk) begin
        if (reset) begin
            for (int i = 0; i < CH_NUM; i++) begin
                wrPtr_q[i] <= '0;
                rdPtr_q[i] <= '0;
            end
            inReady_q  <= '1;
            overflow_q <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                wrPtr_q[i] <= wrPtr_d[i];
                rdPtr_q[i] <= rdPtr_d[i];
                if (push[i]) begin
                    mem_q[i][wrPtr_q[i][AW-1:0]] <= in_bits[i*DATA_W +: DATA_W];
                end
                inReady_q[i] <= ~full_d[i];
                if (in_valid[i] & ~inReady_q[i] & ~flush[i]) begin
                    overflow_q[i] <= 1'b1;
                end
            end
        end
    end

    // Transmit FSM with registered grant/data_send/busy.
    // IDLE latches the winner's head byte.
    // SEND holds the byte until data_ready arrives or the winner is flushed.
    always_ff @(posedge uart_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            dataSend_q <= IDLE_BYTE;
            busy_q     <= 1'b0;
            winIdx_q   <= '0;
`ifdef UART_TX_ARB_RR_EN
            rrPtr_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyEligible) begin
                        state_q    <= SEND;
                        grant_q    <= CH_NUM'(1) << pick;
                        dataSend_q <= mem_q[pick][rdPtr_q[pick][AW-1:0]];
                        busy_q     <= 1'b1;
                        winIdx_q   <= pick;
`ifdef UART_TX_ARB_RR_EN
                        rrPtr_q    <= (int'(pick) == CH_NUM - 1) ? '0 : pick + CW'(1);
`endif
                    end
                end
                SEND: begin
                    if (flush[winIdx_q] || data_ready) begin
                        state_q    <= IDLE;
                        grant_q    <= '0;
                        dataSend_q <= IDLE_BYTE;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign overflow  = overflow_q;
    assign grant     = grant_q;
    assign data_send = dataSend_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Bench for uart_tx_arbiter.
// It uses a queue-based reference model and honours UART_TX_ARB_RR_EN the same
// way the design does.
module tb_uart_tx_arbiter;

    localparam int          CH_NUM    = 2;
    localparam int          DEPTH     = 4;
    localparam int          DATA_W    = 8;
    localparam logic [7:0]  IDLE_BYTE = 8'h00;
`ifdef UART_TX_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        uart_clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ch_enable = '0;
    logic [1:0]  flush = '0;
    logic [15:0] in_bits = '0;
    logic [1:0]  in_valid = '0;
    logic [1:0]  in_ready;
    logic [1:0]  overflow;
    logic        data_ready = 1'b0;
    logic [7:0]  data_send;
    logic [1:0]  grant;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    // Reference model state.
    // mOwner is the channel currently being sent, or -1 when no byte is owned.
    logic [7:0] mq [CH_NUM][$];
    int         mOwner = -1;
    int         mRr = 0;
    logic [7:0] mByte = 8'h00;
    logic [1:0] mOvf = '0;

    uart_tx_arbiter #(
        .CH_NUM   (CH_NUM),
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .IDLE_BYTE(IDLE_BYTE)
    ) dut (
        .uart_clk  (uart_clk),
        .reset     (reset),
        .ch_enable (ch_enable),
        .flush     (flush),
        .in_bits   (in_bits),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .overflow  (overflow),
        .data_ready(data_ready),
        .data_send (data_send),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, observed, expected);
        end
    endtask

    // One clock of the model.
    // Readiness comes from the queue depth before the edge. Arbitration and popping
    // use the queues before the edge. Flushes and pushes are applied afterwards.
    task automatic modelStep(input logic [1:0] en, input logic [1:0] fl, input logic [1:0] val,
                             input logic [15:0] bits, input logic dr, input logic rst);
        logic [1:0] rdy;
        int         pick;
        int         c;
        if (rst) begin
            for (int i = 0; i < CH_NUM; i++) mq[i].delete();
            mOwner = -1;
            mRr    = 0;
            mOvf   = '0;
            return;
        end
        for (int i = 0; i < CH_NUM; i++) rdy[i] = (mq[i].size() < DEPTH);
        if (mOwner >= 0) begin
            if (fl[mOwner]) begin
                mOwner = -1;
            end else if (dr) begin
                void'(mq[mOwner].pop_front());
                mOwner = -1;
            end
        end else begin
            pick = -1;
            for (int k = 0; k < CH_NUM; k++) begin
                c = RR_MODE ? (mRr + k) % CH_NUM : k;
                if (pick < 0 && en[c] && !fl[c] && mq[c].size() > 0) pick = c;
            end
            if (pick >= 0) begin
                mOwner = pick;
                mByte  = mq[pick][0];
                mRr    = (pick + 1) % CH_NUM;
            end
        end
        for (int i = 0; i < CH_NUM; i++) begin
            if (fl[i]) begin
                mq[i].delete();
            end else if (val[i]) begin
                if (rdy[i]) mq[i].push_back(bits[i*8 +: 8]);
                else        mOvf[i] = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs, step the model and compare every output.
    task automatic applyStimulus(input logic [1:0] en, input logic [1:0] fl, input logic [1:0] val,
                                 input logic [15:0] bits, input logic dr, input logic rst);
        logic [1:0] expGrant;
        logic [1:0] expReady;
        ch_enable  = en;
        flush      = fl;
        in_valid   = val;
        in_bits    = bits;
        data_ready = dr;
        reset      = rst;
        @(posedge uart_clk);
        #1;
        cycle++;
        modelStep(en, fl, val, bits, dr, rst);
        expGrant = (mOwner >= 0) ? (2'b01 << mOwner) : 2'b00;
        for (int i = 0; i < CH_NUM; i++) expReady[i] = (mq[i].size() < DEPTH);
        checkOutput("grant", {30'd0, grant}, {30'd0, expGrant});
        checkOutput("data_send", {24'd0, data_send}, {24'd0, (mOwner >= 0) ? mByte : IDLE_BYTE});
        checkOutput("busy", {31'd0, busy}, {31'd0, (mOwner >= 0)});
        checkOutput("in_ready", {30'd0, in_ready}, {30'd0, expReady});
        checkOutput("overflow", {30'd0, overflow}, {30'd0, mOvf});
    endtask

    initial begin
        logic [1:0] order [6];
        logic [7:0] ch1Bytes [4];
        logic [1:0] en;
        logic [1:0] fl;
        logic [1:0] val;
        logic       dr;
        logic       rst;
        int         loadPct;

        // Reset values.
        applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1);
        checkOutput("reset_ready", {30'd0, in_ready}, 32'h3);
        checkOutput("reset_grant", {30'd0, grant}, 32'h0);

        // Single byte on ch0: granted two cycles after the push, released on data_ready.
        applyStimulus(2'b01, 2'b00, 2'b01, 16'h00A5, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
        checkOutput("a5_grant", {30'd0, grant}, 32'h1);
        checkOutput("a5_data", {24'd0, data_send}, 32'hA5);
        applyStimulus(2'b01, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0);
        checkOutput("a5_release", {30'd0, grant}, 32'h0);

        // Overfill ch1 and fill ch0 while both channels are disabled.
        applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1);
        ch1Bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int j = 0; j < 4; j++) applyStimulus(2'b00, 2'b00, 2'b11, {ch1Bytes[j], 8'hC0 + 8'(j)}, 1'b0, 1'b0);
        checkOutput("full_ready", {30'd0, in_ready}, 32'h0);
        applyStimulus(2'b00, 2'b00, 2'b10, 16'h5500, 1'b0, 1'b0);
        checkOutput("ovf_ch1", {31'd0, overflow[1]}, 32'h1);
        for (int j = 0; j < 3; j++) applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0);
        checkOutput("disabled_grant", {30'd0, grant}, 32'h0);
        checkOutput("disabled_data", {24'd0, data_send}, {24'd0, IDLE_BYTE});
        for (int j = 0; j < 4; j++) begin
            applyStimulus(2'b10, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
            checkOutput("ch1_order", {24'd0, data_send}, {24'd0, ch1Bytes[j]});
            applyStimulus(2'b10, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0);
        end
        applyStimulus(2'b10, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
        checkOutput("ch1_drained", {30'd0, grant}, 32'h0);

        // Grant order with three bytes in each channel.
        applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) applyStimulus(2'b00, 2'b00, 2'b11, {8'hB0 + 8'(j), 8'hA0 + 8'(j)}, 1'b0, 1'b0);
        if (RR_MODE) order = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        else         order = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
        for (int j = 0; j < 6; j++) begin
            applyStimulus(2'b11, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
            checkOutput("arb_order", {30'd0, grant}, {30'd0, order[j]});
            applyStimulus(2'b11, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0);
        end

        // Flush of the winner in the middle of a SEND.
        applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1);
        applyStimulus(2'b01, 2'b00, 2'b01, 16'h003C, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
        checkOutput("3c_data", {24'd0, data_send}, 32'h3C);
        applyStimulus(2'b01, 2'b01, 2'b00, 16'h0000, 1'b0, 1'b0);
        checkOutput("flush_busy", {31'd0, busy}, 32'h0);
        applyStimulus(2'b01, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0);
        checkOutput("flush_empty", {30'd0, grant}, 32'h0);

        // Reset during a SEND.
        applyStimulus(2'b10, 2'b00, 2'b10, 16'h7700, 1'b0, 1'b0);
        applyStimulus(2'b10, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
        checkOutput("pre_reset_busy", {31'd0, busy}, 32'h1);
        applyStimulus(2'b10, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1);
        checkOutput("reset_send_grant", {30'd0, grant}, 32'h0);
        applyStimulus(2'b10, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
        checkOutput("reset_send_empty", {30'd0, grant}, 32'h0);

        // Random traffic that alternates between light and heavy load.
        for (int n = 0; n < 4000; n++) begin
            loadPct = ((n / 500) % 2 == 0) ? 25 : 70;
            en = ($urandom_range(0, 5) != 0) ? 2'b11 : 2'($urandom);
            for (int i = 0; i < CH_NUM; i++) begin
                fl[i]  = ($urandom_range(0, 24) == 0);
                val[i] = ($urandom_range(0, 99) < loadPct);
            end
            dr  = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 399) == 0);
            applyStimulus(en, fl, val, 16'($urandom), dr, rst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
